// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH x {instr, pc2}, 1-cycle enqueue-to-dec_valid, no bypass.
// Backpressure: fetch_ready drops when full or once a halt is queued; flush empties everything.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_valid,
  input  logic [WIDTH-1:0]         fetch_instr,
  input  logic [WIDTH-1:0]         fetch_pc2,
  output logic                     fetch_ready,
  output logic                     dec_valid,
  output logic [WIDTH-1:0]         dec_instr,
  output logic [WIDTH-1:0]         dec_pc2,
  input  logic                     dec_ready,
  input  logic                     flush,
  output logic                     halt_pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc2_mem   [DEPTH];
  logic             enq;
  logic             deq;
  logic             is_halt;

  // Ready is derived from registered state only, so no fetch_valid -> fetch_ready path.
  assign fetch_ready = (count != CW'(DEPTH)) & ~halt_pending;
  assign dec_valid   = (count != '0);
  assign dec_instr   = dec_valid ? instr_mem[rd_ptr] : WIDTH'(16'h0800);
  assign dec_pc2     = dec_valid ? pc2_mem[rd_ptr]   : '0;

  assign enq     = fetch_valid & fetch_ready & ~flush;
  assign deq     = dec_valid & dec_ready & ~flush;
  assign is_halt = (fetch_instr[WIDTH-1 -: 5] == 5'b00000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt_pending <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      halt_pending <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (is_halt) halt_pending <= 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left unreset; the valid range is tracked by pointers/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= fetch_instr;
      pc2_mem[wr_ptr]   <= fetch_pc2;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: reset, fill/drain, streaming wrap, flush, halt, full+dequeue.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [15:0] fetch_instr;
  logic [15:0] fetch_pc2;
  logic        fetch_ready;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc2;
  logic        dec_ready;
  logic        flush;
  logic        halt_pending;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_queue #(.DEPTH(4), .WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc2   (fetch_pc2),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc2     (dec_pc2),
    .dec_ready   (dec_ready),
    .flush       (flush),
    .halt_pending(halt_pending),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc2);
    fetch_valid = 1'b1;
    fetch_instr = instr;
    fetch_pc2   = pc2;
    step();
    fetch_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc2 = '0;
    dec_ready = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_instr", dec_instr, 16'h0800);
    chk("rst_dec_pc2", dec_pc2, 0);
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_halt", halt_pending, 0);

    // Asynchronous reset mid-cycle with two entries held
    push(16'h1111, 16'h0002);
    push(16'h2222, 16'h0004);
    chk("pre_arst_count", count, 2);
    chk("pre_arst_head", dec_instr, 16'h1111);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_dec_valid", dec_valid, 0);
    chk("arst_dec_instr", dec_instr, 16'h0800);
    chk("arst_fetch_ready", fetch_ready, 1);
    #1 rst = 1'b0;
    step();

    // Fill to full with decode stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", fetch_ready, 1);
      push(16'h4001 + 16'(i), 16'h0002 + 16'(2 * i));
    end
    chk("full_count", count, 4);
    chk("full_ready", fetch_ready, 0);
    push(16'h4005, 16'h000a);
    chk("full_ignored_count", count, 4);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", dec_valid, 1);
      chk("drain_instr", dec_instr, 16'h4001 + 16'(i));
      chk("drain_pc2", dec_pc2, 16'h0002 + 16'(2 * i));
      step();
    end
    chk("drained_valid", dec_valid, 0);
    chk("drained_count", count, 0);
    dec_ready = 1'b0;

    // Streaming through the pointer wrap; first edge is the empty enq+dec_ready case
    fetch_valid = 1'b1;
    dec_ready   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fetch_instr = 16'h5000 + 16'(i);
      fetch_pc2   = 16'(2 * i);
      step();
      chk("stream_count", count, 1);
      chk("stream_instr", dec_instr, 16'h5000 + 16'(i));
      chk("stream_pc2", dec_pc2, 16'(2 * i));
    end
    fetch_valid = 1'b0;
    step();
    chk("stream_end_count", count, 0);
    dec_ready = 1'b0;

    // Flush beats simultaneous fetch and decode handshakes
    push(16'h6001, 16'h0002);
    push(16'h6002, 16'h0004);
    push(16'h6003, 16'h0006);
    chk("preflush_count", count, 3);
    fetch_valid = 1'b1; fetch_instr = 16'h6fff; dec_ready = 1'b1; flush = 1'b1;
    step();
    fetch_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", dec_valid, 0);
    chk("flush_ready", fetch_ready, 1);
    chk("flush_dec_instr", dec_instr, 16'h0800);
    push(16'h7001, 16'h0010);
    chk("postflush_head", dec_instr, 16'h7001);
    chk("postflush_count", count, 1);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;

    // Halt stops further enqueues but itself drains normally
    push(16'h4005, 16'h0020);
    chk("prehalt_halt", halt_pending, 0);
    chk("prehalt_ready", fetch_ready, 1);
    push(16'h0000, 16'h0022);
    chk("halt_set", halt_pending, 1);
    chk("halt_ready", fetch_ready, 0);
    chk("halt_count", count, 2);
    push(16'h4006, 16'h0024);
    chk("halt_block_count", count, 2);
    dec_ready = 1'b1;
    chk("halt_dec0", dec_instr, 16'h4005);
    step();
    chk("halt_dec1", dec_instr, 16'h0000);
    chk("halt_dec1_pc2", dec_pc2, 16'h0022);
    step();
    dec_ready = 1'b0;
    chk("halt_drained", dec_valid, 0);
    chk("halt_sticky", halt_pending, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halt_cleared", halt_pending, 0);
    chk("halt_clear_ready", fetch_ready, 1);

    // Full with simultaneous dequeue: no write-through
    for (int i = 0; i < 4; i++) push(16'h8001 + 16'(i), 16'(i));
    chk("full2_count", count, 4);
    fetch_valid = 1'b1; fetch_instr = 16'h8005; fetch_pc2 = 16'h0004; dec_ready = 1'b1;
    chk("full2_ready_before", fetch_ready, 0);
    step();
    dec_ready = 1'b0;
    chk("full2_count_after", count, 3);
    chk("full2_ready_after", fetch_ready, 1);
    chk("full2_head", dec_instr, 16'h8002);
    step();
    fetch_valid = 1'b0;
    chk("full2_refill", count, 4);
    chk("full2_refill_ready", fetch_ready, 0);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full2_drain", dec_instr, 16'h8002 + 16'(i));
      step();
    end
    dec_ready = 1'b0;
    chk("full2_empty", dec_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
